seq_shifter: RTL

Multi-cycle iterative shift unit that computes the same SLL/SRL/SRA results as the single-cycle combinational shifter, shifting one bit (or, optionally, four bits) per clock. It sits beside the ALU in the multi-cycle datapath: the control unit issues a request with `start`, stalls while `busy`, and captures `r` on `done`. It trades latency for area on builds without a full barrel shifter.

---
 rtl/seq_shifter.sv | 112 +++++++++++
 1 files changed

// File: rtl/seq_shifter.sv
// seq_shifter: iterative SLL/SRL/SRA unit that shifts one bit per clock.
// Define SEQ_SHIFTER_FAST_EN to take 4-bit steps while at least four bits remain.
module seq_shifter #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [SHW-1:0]   shamt_i,
  input  logic [1:0]       type_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] r_o
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  localparam logic [1:0] OP_SLL = 2'd0;
  localparam logic [1:0] OP_SRL = 2'd1;
  localparam logic [1:0] OP_SRA = 2'd2;
  localparam logic [1:0] OP_RSV = 2'd3;

  state_e           state_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] r_q;
  logic [SHW-1:0]   cnt_q;
  logic [SHW-1:0]   cnt_d;
  logic [SHW-1:0]   step_amt;
  logic [1:0]       op_q;
  logic             busy_q;
  logic             done_q;
  logic             last_step;
  logic             quick;

  // Zero shift or the reserved op skip SHIFT and complete in the next cycle.
  assign quick = (shamt_i == '0) || (type_i == OP_RSV);

  always_comb begin
`ifdef SEQ_SHIFTER_FAST_EN
    step_amt = (cnt_q >= SHW'(4)) ? SHW'(4) : SHW'(1);
`else
    step_amt = SHW'(1);
`endif
    cnt_d     = cnt_q - step_amt;
    last_step = (cnt_d == '0);
    acc_d     = acc_q;
    case (op_q)
      OP_SLL:  acc_d = acc_q << step_amt;
      OP_SRL:  acc_d = acc_q >> step_amt;
      OP_SRA:  acc_d = $unsigned($signed(acc_q) >>> step_amt);
      default: acc_d = acc_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      op_q    <= OP_SLL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      r_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        SHIFT: begin
          acc_q <= acc_d;
          cnt_q <= cnt_d;
          if (last_step) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            r_q     <= (op_q == OP_RSV) ? '0 : acc_d;
          end
        end
        // IDLE and DONE both accept a new request; DONE gives back-to-back issue.
        default: begin
          if (start_i) begin
            acc_q <= a_i;
            cnt_q <= shamt_i;
            op_q  <= type_i;
            if (quick) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              r_q     <= (type_i == OP_RSV) ? '0 : a_i;
            end else begin
              state_q <= SHIFT;
              busy_q  <= 1'b1;
            end
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign r_o    = r_q;

endmodule
